// File: rtl/grid_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | grid_loader_if : byte-stream handshake into the grid loader           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface grid_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_sof;

   modport master (
      output in_valid,
      output in_data,
      output in_sof,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_sof,
      output in_ready
   );
endinterface
`default_nettype wire

// File: rtl/grid_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | grid_loader : assembles a byte-streamed cell grid in a shadow buffer, |
// | publishes it on o_cells_out and pulses o_overwrite for the cell array.|
// | Optional trailing XOR checksum: define GRID_LOADER_CHECKSUM_EN.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module grid_loader #(
   parameter int CELLS_X   = 32,
   parameter int CELLS_Y   = 18,
   parameter int PULSE_LEN = 2
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   grid_loader_if.slave                    s_in,
   input  wire logic                       i_err_clr,
   output logic [CELLS_X*CELLS_Y-1:0]      o_cells_out,
   output logic                            o_overwrite,
   output logic                            o_busy,
   output logic                            o_err
);

   localparam int C_BITS  = CELLS_X * CELLS_Y;
   localparam int C_BYTES = C_BITS / 8;
   localparam int C_IW    = $clog2(C_BYTES + 1);
   localparam int C_PW    = $clog2(PULSE_LEN + 1);

   localparam logic [C_IW-1:0] C_LAST_IDX   = C_IW'(C_BYTES - 1);
   localparam logic [C_IW-1:0] C_IDX_ONE    = C_IW'(1);
   localparam logic [C_PW-1:0] C_PULSE_LAST = C_PW'(PULSE_LEN - 1);

`ifdef GRID_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CHECK  = 3'd2,
      S_COMMIT = 3'd3,
      S_PULSE  = 3'd4
   } state_t;
   localparam state_t C_AFTER_LAST = S_CHECK;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_COMMIT = 3'd3,
      S_PULSE  = 3'd4
   } state_t;
   localparam state_t C_AFTER_LAST = S_COMMIT;
`endif

   // A one-byte grid completes on its start-of-frame byte.
   localparam state_t C_FIRST_NEXT = (C_BYTES == 1) ? C_AFTER_LAST : S_LOAD;

   state_t              r_state;
   state_t              w_next;
   logic [C_IW-1:0]     r_idx;
   logic [C_IW-1:0]     w_idx_next;
   logic [C_PW-1:0]     r_pcnt;
   logic [C_PW-1:0]     w_pcnt_next;
   logic [C_BITS-1:0]   r_shadow;
   logic [C_BITS-1:0]   r_cells;
   logic                r_in_ready;
   logic                r_overwrite;
   logic                r_err;
   logic                w_xfer;
   logic                w_store;
   logic [C_IW-1:0]     w_store_idx;
   logic                w_err_evt;
   logic                w_commit;
   logic                w_ready_next;
`ifdef GRID_LOADER_CHECKSUM_EN
   logic [7:0]          r_xor;
   logic [7:0]          w_xor_next;
`endif

   assign w_xfer      = s_in.in_valid & r_in_ready;
   assign s_in.in_ready = r_in_ready;
   assign o_cells_out = r_cells;
   assign o_overwrite = r_overwrite;
   assign o_err       = r_err;
   assign o_busy      = (r_state != S_IDLE) | r_overwrite;

   always_comb begin
      w_next      = r_state;
      w_idx_next  = r_idx;
      w_pcnt_next = r_pcnt;
      w_store     = 1'b0;
      w_store_idx = '0;
      w_err_evt   = 1'b0;
      w_commit    = 1'b0;
`ifdef GRID_LOADER_CHECKSUM_EN
      w_xor_next  = r_xor;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               if (s_in.in_sof) begin
                  w_store    = 1'b1;
                  w_idx_next = C_IDX_ONE;
                  w_next     = C_FIRST_NEXT;
`ifdef GRID_LOADER_CHECKSUM_EN
                  w_xor_next = s_in.in_data;
`endif
               end else begin
                  w_err_evt = 1'b1;
               end
            end
         end

         S_LOAD: begin
            if (w_xfer) begin
               w_store = 1'b1;
               if (s_in.in_sof) begin
                  // Restart: the partial frame is abandoned, this byte becomes byte 0.
                  w_err_evt  = 1'b1;
                  w_idx_next = C_IDX_ONE;
                  w_next     = C_FIRST_NEXT;
`ifdef GRID_LOADER_CHECKSUM_EN
                  w_xor_next = s_in.in_data;
`endif
               end else begin
                  w_store_idx = r_idx;
                  w_idx_next  = r_idx + C_IDX_ONE;
`ifdef GRID_LOADER_CHECKSUM_EN
                  w_xor_next  = r_xor ^ s_in.in_data;
`endif
                  if (r_idx == C_LAST_IDX) begin
                     w_next = C_AFTER_LAST;
                  end
               end
            end
         end

`ifdef GRID_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (w_xfer) begin
               if (s_in.in_sof) begin
                  w_store    = 1'b1;
                  w_err_evt  = 1'b1;
                  w_idx_next = C_IDX_ONE;
                  w_xor_next = s_in.in_data;
                  w_next     = C_FIRST_NEXT;
               end else begin
                  w_idx_next = '0;
                  if (s_in.in_data == r_xor) begin
                     w_next = S_COMMIT;
                  end else begin
                     w_err_evt = 1'b1;
                     w_next    = S_IDLE;
                  end
               end
            end
         end
`endif

         S_COMMIT: begin
            w_commit    = 1'b1;
            w_idx_next  = '0;
            w_pcnt_next = '0;
            w_next      = S_PULSE;
         end

         S_PULSE: begin
            w_pcnt_next = r_pcnt + C_PW'(1);
            if (r_pcnt == C_PULSE_LAST) begin
               w_next = S_IDLE;
            end
         end

         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

`ifdef GRID_LOADER_CHECKSUM_EN
   assign w_ready_next = (w_next == S_IDLE) | (w_next == S_LOAD) | (w_next == S_CHECK);
`else
   assign w_ready_next = (w_next == S_IDLE) | (w_next == S_LOAD);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_pcnt      <= '0;
         r_in_ready  <= 1'b0;
         r_overwrite <= 1'b0;
         r_err       <= 1'b0;
         r_cells     <= '0;
      end else begin
         r_state     <= w_next;
         r_idx       <= w_idx_next;
         r_pcnt      <= w_pcnt_next;
         r_in_ready  <= w_ready_next;
         // Lags the PULSE state by one cycle so o_cells_out settles before the strobe.
         r_overwrite <= (r_state == S_PULSE);
         if (w_commit) begin
            r_cells <= r_shadow;
         end
         if (w_err_evt) begin
            r_err <= 1'b1;
         end else if (i_err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else begin
         for (int b = 0; b < C_BYTES; b++) begin
            if (w_store && (w_store_idx == C_IW'(b))) begin
               r_shadow[8*b +: 8] <= s_in.in_data;
            end
         end
      end
   end

`ifdef GRID_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xor <= '0;
      end else begin
         r_xor <= w_xor_next;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_grid_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_grid_loader : self-checking bench for grid_loader                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_grid_loader;
   localparam int CX = 32;
   localparam int CY = 18;
   localparam int PL = 2;
   localparam int GW = CX * CY;
   localparam int NB = GW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          err_clr = 1'b0;
   logic [GW-1:0] cells;
   logic          ow, busy, err;

   grid_loader_if ifc ();

   grid_loader #(.CELLS_X(CX), .CELLS_Y(CY), .PULSE_LEN(PL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_in        (ifc),
      .i_err_clr   (err_clr),
      .o_cells_out (cells),
      .o_overwrite (ow),
      .o_busy      (busy),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   bit            exp_err = 1'b0;
   logic [7:0]    fb[$];
   logic [GW-1:0] exp_q[$];
   int            exp_pulses = 0;
   int            seen_pulses = 0;
   logic [7:0]    tx [NB];

   typedef struct {
      logic [7:0] fill;
      logic       b0;
      logic       b575;
      int         ones;
   } vec_t;
   vec_t tbl [7];

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkg(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: a frame is the ordered list of accepted bytes; a complete
   // frame becomes a grid in which byte i occupies bits 8i..8i+7.
   function automatic void commit_frame();
      logic [GW-1:0] g = '0;
      for (int i = 0; i < NB; i++) g[8*i +: 8] = fb[i];
      exp_q.push_back(g);
      exp_pulses++;
   endfunction

   function automatic void model_push(input logic [7:0] d, input logic s);
`ifdef GRID_LOADER_CHECKSUM_EN
      logic [7:0] x = '0;
      if (!s && fb.size() == NB) begin
         foreach (fb[i]) x ^= fb[i];
         if (x == d) commit_frame();
         else exp_err = 1'b1;
         fb.delete();
         return;
      end
`endif
      if (s) begin
         if (fb.size() != 0) exp_err = 1'b1;
         fb.delete();
         fb.push_back(d);
      end else if (fb.size() == 0) begin
         exp_err = 1'b1;
         return;
      end else begin
         fb.push_back(d);
      end
`ifndef GRID_LOADER_CHECKSUM_EN
      if (fb.size() == NB) begin
         commit_frame();
         fb.delete();
      end
`endif
   endfunction

   // Overwrite watcher: every strobe must carry the next expected grid, present
   // already on the cycle before the strobe, and last exactly PL cycles.
   initial begin : mon
      logic          prev_ow;
      logic [GW-1:0] prev_cells;
      int            plen;
      prev_ow = 1'b0;
      prev_cells = '0;
      plen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ow = 1'b0;
            plen = 0;
            prev_cells = cells;
         end else begin
            if (ow && !prev_ow) begin
               seen_pulses++;
               plen = 1;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL spurious_overwrite: got pulse expected none");
               end else begin
                  chkg("cells_before_ow", prev_cells, exp_q[0]);
                  chkg("cells_at_ow", cells, exp_q.pop_front());
               end
            end else if (ow) begin
               plen++;
            end else if (prev_ow) begin
               chki("ow_len", plen, PL);
            end
            prev_ow = ow;
            prev_cells = cells;
         end
      end
   end

   task automatic xfer(input logic [7:0] d, input logic s);
      bit ok = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_sof   = s;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (ifc.in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL xfer_timeout: in_ready got 0 expected 1");
      end else begin
         model_push(d, s);
      end
   endtask

   task automatic gap(input int n);
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'($urandom);
      ifc.in_sof   = 1'($urandom);
      repeat (n) @(posedge clk);
      if (n > 0) #1;
   endtask

   task automatic send_tx(input int gapmax);
`ifdef GRID_LOADER_CHECKSUM_EN
      logic [7:0] x = '0;
`endif
      for (int i = 0; i < NB; i++) begin
         gap($urandom_range(0, gapmax));
         xfer(tx[i], (i == 0));
`ifdef GRID_LOADER_CHECKSUM_EN
         x ^= tx[i];
`endif
      end
`ifdef GRID_LOADER_CHECKSUM_EN
      xfer(x, 1'b0);
`endif
   endtask

   task automatic fill_tx(input logic [7:0] b);
      for (int i = 0; i < NB; i++) tx[i] = b;
   endtask

   function automatic logic [GW-1:0] pack_tx();
      logic [GW-1:0] g = '0;
      for (int i = 0; i < NB; i++) g[8*i +: 8] = tx[i];
      return g;
   endfunction

   task automatic drain();
      bit done = 1'b0;
      ifc.in_valid = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !ow && !busy) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: loader still busy, expected idle");
      end
   endtask

   task automatic clr_err();
      ifc.in_valid = 1'b0;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      exp_err = 1'b0;
   endtask

   initial begin : global_timeout
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int            p0;
      logic [GW-1:0] g;
      bit            seen;

      tbl[0] = '{8'h55, 1'b1, 1'b0, 288};
      tbl[1] = '{8'hAA, 1'b0, 1'b1, 288};
      tbl[2] = '{8'hFF, 1'b1, 1'b1, 576};
      tbl[3] = '{8'h00, 1'b0, 1'b0, 0};
      tbl[4] = '{8'h0F, 1'b1, 1'b0, 288};
      tbl[5] = '{8'h80, 1'b0, 1'b1, 72};
      tbl[6] = '{8'h01, 1'b1, 1'b0, 72};

      ifc.in_valid = 1'b0;
      ifc.in_data  = '0;
      ifc.in_sof   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_ready", ifc.in_ready, 1'b0);
      chk1("rst_ow", ow, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chkg("rst_cells", cells, '0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk1("ready_after_rst", ifc.in_ready, 1'b1);

      // Bytes without start-of-frame in IDLE are dropped and flag an error.
      for (int i = 0; i < 3; i++) xfer(8'($urandom), 1'b0);
      gap(1);
      chk1("idle_drop_err", err, exp_err);
      chkg("idle_drop_cells", cells, '0);
      clr_err();
      chk1("err_clr", err, 1'b0);
      err_clr = 1'b1;
      xfer(8'h12, 1'b0);
      err_clr = 1'b0;
      gap(1);
      chk1("err_beats_clr", err, exp_err);
      clr_err();

      // Cycle-exact commit timing.
      fill_tx(8'h55);
      send_tx(0);
      ifc.in_valid = 1'b0;
      chk1("lat_n_ready", ifc.in_ready, 1'b0);
      chk1("lat_n_ow", ow, 1'b0);
      chk1("lat_n_busy", busy, 1'b1);
      chkg("lat_n_cells_old", cells, '0);
      @(posedge clk); #1;
      chkg("lat_n1_cells", cells, {NB{8'h55}});
      chk1("lat_n1_ow", ow, 1'b0);
      chk1("lat_n1_ready", ifc.in_ready, 1'b0);
      @(posedge clk); #1;
      chk1("lat_n2_ow", ow, 1'b1);
      chk1("lat_n2_ready", ifc.in_ready, 1'b0);
      @(posedge clk); #1;
      chk1("lat_n3_ow", ow, 1'b1);
      chk1("lat_n3_ready", ifc.in_ready, 1'b1);
      @(posedge clk); #1;
      chk1("lat_n4_ow", ow, 1'b0);
      chk1("lat_n4_busy", busy, 1'b0);
      chk1("lat_err", err, 1'b0);
      drain();

      // Partial frame abandoned by a new start-of-frame.
      p0 = seen_pulses;
      for (int i = 0; i < 40; i++) xfer(8'hFF, (i == 0));
      fill_tx(8'h00);
      send_tx(1);
      drain();
      chk1("restart_err", err, 1'b1);
      chk1("restart_err_model", err, exp_err);
      chkg("restart_cells", cells, '0);
      chki("restart_pulses", seen_pulses - p0, 1);
      clr_err();

      for (int v = 0; v < 7; v++) begin
         fill_tx(tbl[v].fill);
         send_tx(2);
         drain();
         chk1("tbl_bit0", cells[0], tbl[v].b0);
         chk1("tbl_bit575", cells[GW-1], tbl[v].b575);
         chki("tbl_ones", $countones(cells), tbl[v].ones);
         chk1("tbl_err", err, 1'b0);
      end

      // Back-to-back random frames: the next frame's first byte is held valid
      // through COMMIT/PULSE.
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
         tx[NB-1] = 8'h80;
         send_tx(3);
      end
      drain();
      chkg("rand_last_cells", cells, pack_tx());
      chki("rand_top_byte", int'(cells[GW-1 -: 8]), 8'h80);
      chk1("rand_err", err, exp_err);

      // Reset in the middle of the overwrite strobe.
      fill_tx(8'h3C);
      send_tx(0);
      ifc.in_valid = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(posedge clk); #1;
         seen = ow;
      end
      chk1("pre_rst_ow", seen, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("midrst_ow", ow, 1'b0);
      chk1("midrst_ready", ifc.in_ready, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chkg("midrst_cells", cells, '0);
      exp_pulses -= exp_q.size();
      exp_q.delete();
      fb.delete();
      exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("postrst_ready", ifc.in_ready, 1'b1);
      for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
      send_tx(1);
      drain();
      chkg("postrst_cells", cells, pack_tx());
      chk1("postrst_err", err, 1'b0);

`ifdef GRID_LOADER_CHECKSUM_EN
      fill_tx(8'h01);
      send_tx(0);
      drain();
      chkg("ck_good_cells", cells, {NB{8'h01}});
      chk1("ck_good_err", err, 1'b0);
      p0 = seen_pulses;
      for (int i = 0; i < NB; i++) xfer(8'h01, (i == 0));
      xfer(8'h01, 1'b0);
      drain();
      chk1("ck_bad_err", err, 1'b1);
      chkg("ck_bad_cells", cells, {NB{8'h01}});
      chki("ck_bad_pulses", seen_pulses - p0, 0);
      clr_err();
`endif

      g = '0;
      chki("pulse_count", seen_pulses, exp_pulses);
      chki("pending_frames", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
